// File: rtl/robot_maneuver_sequencer.sv
// Obstacle-avoidance maneuver sequencer: cruise, back up, turn, pause, then resume,
// stop after one avoidance (single-shot) or latch FAULT on a persistent obstacle.
module robot_maneuver_sequencer #(
  parameter int BACK_CYC  = 4,
  parameter int TURN_CYC  = 6,
  parameter int PAUSE_CYC = 2,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       S,
  input  logic [2:0] I,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic [2:0] L,
  output logic       busy,
  output logic       done
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  // State encoding doubles as the LED pattern.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FWD    = 3'b001,
    ST_BACKUP = 3'b010,
    ST_PAUSE  = 3'b011,
    ST_TURN   = 3'b100,
    ST_FAULT  = 3'b111
  } state_t;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d, retry_inc;
  logic [1:0]       cfg_q, cfg_d;   // {single_shot, alternate}
  logic             dir_q, dir_d;   // 0 left, 1 right
  logic [1:0]       m1_q, m1_d, m2_q, m2_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    cfg_d     = cfg_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    retry_inc = retry_q + RW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          cfg_d   = I[2:1];
          dir_d   = I[0];
          retry_d = '0;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        retry_d = '0;
        if (S) begin
          state_d = ST_BACKUP;
          cnt_d   = CNT_W'(BACK_CYC - 1);
        end
      end
      ST_BACKUP: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          cnt_d   = CNT_W'(TURN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_PAUSE;
          cnt_d   = CNT_W'(PAUSE_CYC - 1);
          if (cfg_q[0]) dir_d = ~dir_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PAUSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (S) begin
          retry_d = retry_inc;
          if (retry_inc == RW'(MAX_RETRY)) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_BACKUP;
            cnt_d   = CNT_W'(BACK_CYC - 1);
          end
        end else if (cfg_q[1]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FWD;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every other transition, including counter expiry.
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    m1_d   = MOT_STOP;
    m2_d   = MOT_STOP;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_FWD:    begin m1_d = MOT_FWD; m2_d = MOT_FWD; end
      ST_BACKUP: begin m1_d = MOT_REV; m2_d = MOT_REV; end
      ST_TURN: begin
        m1_d = dir_d ? MOT_FWD : MOT_REV;
        m2_d = dir_d ? MOT_REV : MOT_FWD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      cfg_q   <= '0;
      dir_q   <= 1'b0;
      m1_q    <= MOT_STOP;
      m2_q    <= MOT_STOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      cfg_q   <= cfg_d;
      dir_q   <= dir_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign M1   = m1_q;
  assign M2   = m2_q;
  assign L    = state_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_robot_maneuver_sequencer.sv
// Scoreboard bench for robot_maneuver_sequencer with default parameters.
module tb_robot_maneuver_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, S;
  logic [2:0] I;
  logic [1:0] M1, M2;
  logic [2:0] L;
  logic       busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  // Expected observation {M1, M2, L, busy, done}
  localparam logic [8:0] E_IDLE  = {2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [8:0] E_FWD   = {2'b01, 2'b01, 3'b001, 1'b1, 1'b0};
  localparam logic [8:0] E_BACK  = {2'b10, 2'b10, 3'b010, 1'b1, 1'b0};
  localparam logic [8:0] E_TL    = {2'b10, 2'b01, 3'b100, 1'b1, 1'b0};
  localparam logic [8:0] E_TR    = {2'b01, 2'b10, 3'b100, 1'b1, 1'b0};
  localparam logic [8:0] E_PAUSE = {2'b00, 2'b00, 3'b011, 1'b1, 1'b0};
  localparam logic [8:0] E_FAULT = {2'b00, 2'b00, 3'b111, 1'b1, 1'b0};
  localparam logic [8:0] E_DONE  = {2'b00, 2'b00, 3'b000, 1'b0, 1'b1};

  robot_maneuver_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .S(S), .I(I),
    .M1(M1), .M2(M2), .L(L), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got M1M2_L_busy_done=%b required=%b", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push the expectation, compare after the edge.
  task automatic cyc(input logic rst_n, input logic st, input logic sp, input logic s,
                     input logic [2:0] i, input logic [8:0] e, input string tag);
    @(negedge clk);
    reset = rst_n; start = st; stop = sp; S = s; I = i;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s scoreboard empty got=%b required=entry", tag, {M1, M2, L, busy, done});
    end else begin
      check_eq(tag_q.pop_front(), {M1, M2, L, busy, done}, exp_q.pop_front());
    end
  endtask

  task automatic run(input int n, input logic s, input logic [8:0] e, input string tag);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, s, 3'b000, e, tag);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; S = 1'b0; I = 3'b000;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, E_IDLE, "reset");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, E_IDLE, "reset_prio");
    run(2, 1'b0, E_IDLE, "idle_hold");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, E_IDLE, "start_and_stop");

    // Single avoidance, left turn, then resume cruising
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, E_FWD, "start_fwd");
    run(2, 1'b0, E_FWD, "cruise");
    run(4, 1'b1, E_BACK, "avoid_back");
    run(6, 1'b0, E_TL, "avoid_turn_left");
    run(2, 1'b0, E_PAUSE, "avoid_pause");
    run(2, 1'b0, E_FWD, "avoid_resume");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, E_FWD, "start_ignored_in_fwd");

    // Reset in the middle of a turn
    run(4, 1'b1, E_BACK, "rst_back");
    run(2, 1'b0, E_TL, "rst_turn");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, E_IDLE, "reset_mid_turn");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, E_FWD, "restart_fwd");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, E_IDLE, "stop_fwd");

    // Alternating direction starting right; I is dropped after start
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, E_FWD, "alt_start");
    run(4, 1'b1, E_BACK, "alt1_back");
    run(6, 1'b0, E_TR, "alt1_turn_right");
    run(2, 1'b0, E_PAUSE, "alt1_pause");
    run(1, 1'b0, E_FWD, "alt1_resume");
    run(4, 1'b1, E_BACK, "alt2_back");
    run(6, 1'b0, E_TL, "alt2_turn_left");
    run(2, 1'b0, E_PAUSE, "alt2_pause");
    run(1, 1'b0, E_FWD, "alt2_resume");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, E_IDLE, "alt_stop");

    // Single-shot completion
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, E_FWD, "ss_start");
    run(4, 1'b1, E_BACK, "ss_back");
    run(6, 1'b0, E_TL, "ss_turn");
    run(2, 1'b0, E_PAUSE, "ss_pause");
    run(1, 1'b0, E_DONE, "ss_done");
    run(2, 1'b0, E_IDLE, "ss_idle");

    // Persistent obstacle leads to FAULT after three rounds
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, E_FWD, "pers_start");
    for (int r = 0; r < 3; r++) begin
      run(4, 1'b1, E_BACK, "pers_back");
      run(6, 1'b1, E_TL, "pers_turn");
      run(2, 1'b1, E_PAUSE, "pers_pause");
    end
    run(1, 1'b1, E_FAULT, "pers_fault");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, E_FAULT, "fault_hold");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, E_IDLE, "fault_stop");

    // Stop on the same edge the backup counter expires
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, E_FWD, "sx_start");
    run(4, 1'b1, E_BACK, "sx_back");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, E_IDLE, "stop_at_back_expiry");
    run(1, 1'b0, E_IDLE, "sx_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/robot_maneuver_sequencer.md
Name: robot_maneuver_sequencer

Overview:
Sequences the robot's two drive motors and status LEDs through timed obstacle-avoidance maneuvers. It replaces direct combinational motor decoding with a cycle-counted controller: cruise forward, back up, turn, pause, then resume or stop. It sits between the sensor/command inputs (S, I_2..I_0, start/stop) and the motor driver pins M1/M2 and LEDs L.

Parameters:
BACK_CYC, 4, cycles spent reversing per avoidance (>=1)
TURN_CYC, 6, cycles spent turning per avoidance (>=1)
PAUSE_CYC, 2, cycles motors are stopped after a turn (>=1)
MAX_RETRY, 3, consecutive avoidances with S still high before FAULT (>=1)
CNT_W, 8, width of the phase counter; must hold max(BACK_CYC, TURN_CYC, PAUSE_CYC)-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets the block
start  input  1  begin a run; sampled only in IDLE
stop  input  1  abort to IDLE from any non-IDLE state
S  input  1  obstacle sensor, 1 = obstacle
I  input  3  config: I[0] turn direction (0 left, 1 right), I[1] alternate direction after each turn, I[2] single-shot (IDLE after one avoidance)
M1  output  2  left motor code
M2  output  2  right motor code
L  output  3  state LEDs
busy  output  1  1 in any state except IDLE
done  output  1  one-cycle pulse on single-shot completion

Behaviour:
- Motor codes: 00 stop, 01 forward, 10 reverse. Forward M1=01,M2=01; reverse 10/10; turn left M1=10,M2=01; turn right M1=01,M2=10.
- All outputs registered, updated on the same edge as the state register. Condition sampled at edge k -> new state and outputs visible after edge k.
- Reset (reset=0 at edge): state IDLE, M1=M2=00, L=000, busy=0, done=0, counters/latched config/retry cleared. Reset takes priority over all inputs, including mid-maneuver.
- States/LEDs: IDLE 000, FWD 001, BACKUP 010, TURN 100, PAUSE 011, FAULT 111.
- IDLE: motors 00. start=1 and stop=0 -> latch I into cfg, dir<=I[0], retry<=0, go FWD.
- FWD: motors forward, retry<=0. S=1 -> BACKUP, cnt<=BACK_CYC-1.
- BACKUP: reverse. cnt==0 -> TURN, cnt<=TURN_CYC-1; else cnt-1.
- TURN: direction from dir. cnt==0 -> PAUSE, cnt<=PAUSE_CYC-1, and dir toggles if cfg[1]; else cnt-1.
- PAUSE: motors 00. On cnt==0: if S=1 -> retry+1; if retry+1==MAX_RETRY -> FAULT, else BACKUP (cnt<=BACK_CYC-1). If S=0: cfg[2]=1 -> IDLE with done=1 for that one cycle; else -> FWD.
- FAULT: motors 00, held until stop=1 (-> IDLE) or reset.
- stop=1 in any non-IDLE state -> IDLE next edge, motors 00, no done pulse; stop beats S and counter expiry on the same edge.
- start ignored outside IDLE; start and stop both 1 in IDLE -> stay IDLE.
- S is ignored in BACKUP/TURN; only FWD and PAUSE-expiry sample it.
- Each phase lasts exactly its parameter in cycles: BACKUP occupies BACK_CYC consecutive cycles.
- I changes after start have no effect until the next start.

Test Plan:
- Reset mid-TURN: drive reset=0 one edge -> next cycle M1=M2=00, L=000, busy=0; start with I=000 -> FWD, M1=M2=01, L=001.
- Single avoidance, defaults, I=000: S pulses 1 for one cycle in FWD -> exactly 4 cycles M=10/10 (L=010), 6 cycles M1=10,M2=01 (L=100), 2 cycles 00/00 (L=011), then FWD.
- Alternate direction I=011: two successive obstacles -> first turn right (M1=01,M2=10), second turn left (M1=10,M2=01).
- Single-shot I=100, S low at PAUSE end -> IDLE with done=1 for exactly one cycle, busy=0.
- Persistent obstacle, S held 1, MAX_RETRY=3 -> three BACKUP/TURN/PAUSE rounds, then FAULT, L=111, motors 00; stop=1 -> IDLE.
- stop asserted on the same edge BACKUP counter reaches 0 -> IDLE (not TURN), motors 00, done=0.
